// File: rtl/matrix_scan_controller_pkg.sv
// Shared sizing, FSM encodings and column-slice helper for the LED matrix
// column scanner.
package matrix_scan_controller_pkg;
    localparam int TOTAL_COLUMNS = 5;
    localparam int COLUMN_SIZE   = 7;
    localparam int DATA_WIDTH    = TOTAL_COLUMNS * COLUMN_SIZE;
    localparam int COL_W         = $clog2(TOTAL_COLUMNS);

    typedef logic [1:0] scan_state_t;
    localparam scan_state_t ST_IDLE  = 2'd0;
    localparam scan_state_t ST_BLANK = 2'd1;
    localparam scan_state_t ST_DRIVE = 2'd2;

    function automatic logic [COLUMN_SIZE-1:0] column_slice(
        input logic [DATA_WIDTH-1:0] map,
        input logic [COL_W-1:0]      c
    );
        return map[int'(c) * COLUMN_SIZE +: COLUMN_SIZE];
    endfunction
endpackage

// File: rtl/scan_timer.sv
// Reloadable down-counter; done is high while the count sits at zero, so a
// reload of N-1 gives a dwell of exactly N cycles.
module scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)               count <= '0;
        else if (load)           count <= load_val;
        else if (count != '0)    count <= count - 1'b1;
    end

    assign done = (count == '0);
endmodule

// File: rtl/matrix_scan_controller.sv
// Column-multiplexed 5x7 LED matrix driver: shadow/active map double buffer
// committed at frame wrap, blanking gaps between columns, per-pixel blinking.
module matrix_scan_controller #(
    parameter int DATA_WIDTH    = matrix_scan_controller_pkg::DATA_WIDTH,
    parameter int COLUMN_SIZE   = matrix_scan_controller_pkg::COLUMN_SIZE,
    parameter int TOTAL_COLUMNS = matrix_scan_controller_pkg::TOTAL_COLUMNS,
    parameter int CLK_DIV       = 50000,
    parameter int BLANK_CYCLES  = 2,
    parameter int BLINK_FRAMES  = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    map_in,
    input  logic [DATA_WIDTH-1:0]    blink_in,
    input  logic                     load,
    output logic [TOTAL_COLUMNS-1:0] column_out,
    output logic [COLUMN_SIZE-1:0]   row_out,
    output logic                     frame_start,
    output logic                     pending
);
    import matrix_scan_controller_pkg::*;

    localparam int TMR_W = $clog2((CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES) + 1);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [TMR_W-1:0] DRIVE_LOAD = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    // With no blanking every column change goes straight to the next DRIVE.
    localparam scan_state_t      GAP_STATE  = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;
    localparam logic [TMR_W-1:0] GAP_LOAD   = (BLANK_CYCLES > 0) ? BLANK_LOAD : DRIVE_LOAD;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(TOTAL_COLUMNS - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [TOTAL_COLUMNS-1:0] COL_ONE = TOTAL_COLUMNS'(1);

    scan_state_t            state, state_n;
    logic [COL_W-1:0]       col, col_n;
    logic                   tmr_load, tmr_done, commit;
    logic [TMR_W-1:0]       tmr_val;
    logic [DATA_WIDTH-1:0]  shadow_map, shadow_mask, active_map, active_mask;
    logic [DATA_WIDTH-1:0]  shadow_map_n, shadow_mask_n, active_map_n, active_mask_n;
    logic [BLK_W-1:0]       blink_cnt, blink_cnt_n;
    logic                   blink_phase, blink_phase_n, pending_n;

    scan_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_n  = state;
        col_n    = col;
        tmr_load = 1'b0;
        tmr_val  = DRIVE_LOAD;
        commit   = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            col_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    commit   = 1'b1;
                    col_n    = '0;
                    state_n  = GAP_STATE;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
                ST_BLANK: if (tmr_done) begin
                    state_n  = ST_DRIVE;
                    tmr_load = 1'b1;
                    tmr_val  = DRIVE_LOAD;
                end
                ST_DRIVE: if (tmr_done) begin
                    if (col == LAST_COL) begin
                        col_n  = '0;
                        commit = 1'b1;
                    end else begin
                        col_n  = col + 1'b1;
                    end
                    state_n  = GAP_STATE;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
                default: begin
                    state_n = ST_IDLE;
                    col_n   = '0;
                end
            endcase
        end
    end

    // A load landing on the commit cycle bypasses the shadow so it is never
    // left pending for a whole extra frame.
    always_comb begin
        shadow_map_n  = shadow_map;
        shadow_mask_n = shadow_mask;
        active_map_n  = active_map;
        active_mask_n = active_mask;
        pending_n     = pending;
        blink_cnt_n   = blink_cnt;
        blink_phase_n = blink_phase;
        if (load) begin
            shadow_map_n  = map_in;
            shadow_mask_n = blink_in;
            pending_n     = 1'b1;
        end
        if (commit) begin
            if (load) begin
                active_map_n  = map_in;
                active_mask_n = blink_in;
            end else if (pending) begin
                active_map_n  = shadow_map;
                active_mask_n = shadow_mask;
            end
            pending_n = 1'b0;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n   = '0;
                blink_phase_n = ~blink_phase;
            end else begin
                blink_cnt_n   = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            col         <= '0;
            shadow_map  <= '1;
            shadow_mask <= '0;
            active_map  <= '1;
            active_mask <= '0;
            pending     <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            column_out  <= '0;
            row_out     <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            shadow_map  <= shadow_map_n;
            shadow_mask <= shadow_mask_n;
            active_map  <= active_map_n;
            active_mask <= active_mask_n;
            pending     <= pending_n;
            blink_cnt   <= blink_cnt_n;
            blink_phase <= blink_phase_n;
            frame_start <= commit;
            if (state_n == ST_DRIVE) begin
                column_out <= COL_ONE << col_n;
                row_out    <= column_slice(active_map_n, col_n)
                            | (column_slice(active_mask_n, col_n) & {COLUMN_SIZE{blink_phase_n}});
            end else begin
                column_out <= '0;
                row_out    <= '1;
            end
        end
    end
endmodule

// File: doc/matrix_scan_controller.md
# matrix_scan_controller

Column-multiplexing controller for the 5x7 LED matrix. Takes the 35-bit active-low pixel map produced by the map decoder and captures it into a shadow register. It commits the map at frame boundaries so the display never tears, then drives one column at a time with blanking gaps and optional per-pixel blinking for attacked cells. It sits between the map decoder and the board's column/row pins.

## Interface
- `DATA_WIDTH`, 35, pixel map width (`TOTAL_COLUMNS*COLUMN_SIZE`)
- `COLUMN_SIZE`, 7, rows per column
- `TOTAL_COLUMNS`, 5, columns a..e
- `CLK_DIV`, 50000, clock cycles a column is driven (≥1)
- `BLANK_CYCLES`, 2, all-off cycles before each column (≥0; 0 skips blanking)
- `BLINK_FRAMES`, 100, frames per blink half-period (≥1)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  scan enable; low blanks the display
- `map_in`  in  35  pixel map; bit `col*7+row`; 0 = lit
- `blink_in`  in  35  blink mask; 1 = pixel blinks
- `load`  in  1  one-cycle strobe; captures `map_in`/`blink_in`
- `column_out`  out  5  one-hot, active-high column enable
- `row_out`  out  7  active-low row data for the driven column
- `frame_start`  out  1  one-cycle pulse when column a begins a new frame
- `pending`  out  1  captured frame is waiting for commit

One clock; reset is synchronous and active-high (`clk`, `reset`).

## Operation
- Registers:
  - shadow map/mask, filled by `load`
  - active map/mask, displayed
  - column index 0..4
  - dwell counter
  - blink frame counter
  - `blink_phase`
- `load`: shadow ← inputs and `pending` ← 1.
- States:
  - IDLE: `column_out`=0, `row_out`=7'h7F, column index=0. Moves to BLANK when `enable`=1, or to DRIVE if `BLANK_CYCLES`=0.
  - BLANK: `column_out`=0, `row_out`=7'h7F for `BLANK_CYCLES` cycles, then DRIVE.
  - DRIVE:
    - `column_out`=one-hot(col).
    - `row_out`=active[col*7+:7] OR (active_mask[col*7+:7] AND {7{blink_phase}}).
    - Held for `CLK_DIV` cycles, then col advances and the FSM returns to BLANK (or DRIVE if `BLANK_CYCLES`=0).
- Frame boundary, when col wraps 4→0 (and on the first IDLE exit):
  - if `pending`, active ← shadow and `pending` ← 0;
  - blink counter +1; on reaching `BLINK_FRAMES` it clears and toggles `blink_phase`;
  - `frame_start` pulses on the first cycle of column 0's BLANK/DRIVE.
- `load` in the same cycle as a commit: the new inputs go directly to active, and `pending` stays 0.
- `enable` low in any state: IDLE on the next cycle. Column index and dwell counter clear; active/shadow/`pending`/blink state are retained.
- `reset` mid-scan: all registers return to reset values on the next edge.

## Timing
- All outputs are registered.
- Reset values:
  - `column_out`=5'b00000
  - `row_out`=7'h7F
  - `frame_start`=0
  - `pending`=0
  - active map=all 1 (dark), masks=0, `blink_phase`=0
- Column period = `CLK_DIV`+`BLANK_CYCLES`; frame period = 5× column period.
- `load` to display latency: at most one frame plus one cycle. `pending` rises the cycle after `load`.
- `enable` rise to first lit column = `BLANK_CYCLES`+1 cycles.
- No two columns are ever active in the same cycle. Column changes always pass through BLANK when `BLANK_CYCLES`>0.

## Structure
- Shared package holds:
  - `TOTAL_COLUMNS`, `COLUMN_SIZE`, `DATA_WIDTH`
  - state enum {IDLE, BLANK, DRIVE}
  - function to slice column `c` from a 35-bit map
- Sub-module `scan_timer`: parameterised down-counter that is reloaded with `CLK_DIV-1` or `BLANK_CYCLES-1` and raises `done` at zero. Instantiate it once.

## Test plan
Bench parameters: `CLK_DIV`=4, `BLANK_CYCLES`=1, `BLINK_FRAMES`=2.

- **Reset and idle.** Hold `reset` 3 cycles with `enable`=1 → `column_out`=0, `row_out`=7'h7F, `pending`=0. Release → cycle 1 BLANK, cycles 2-5 `column_out`=5'b00001, `row_out`=7'h7F (dark map).
- **Load and commit.** `load` with `map_in`=35'h7_FFFF_FFFE (a1 lit) mid-column c → `pending`=1. The next column-a DRIVE shows `row_out`=7'h7E, and `pending`=0 at commit.
- **Scan order and blanking.** Over 25 cycles, `column_out` goes 00001, 00010, 00100, 01000, 10000, each preceded by one all-zero cycle. `frame_start` pulses once per 25 cycles.
- **Blink.** Blink a1 with `blink_in` bit0=1. a1 is lit for 2 frames (50 cycles) and dark for 2 frames, repeating. Other pixels are unaffected.
- **Enable drop.** Drop `enable` during column c DRIVE → next cycle `column_out`=0, `row_out`=7'h7F. Re-enable → scan restarts at column a after 1 BLANK cycle.
- **Simultaneous load and commit.** `load` on the wrap cycle → the new map is shown in column a immediately and `pending` stays 0.
